// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared definitions for the RAM_16-backed FIFO controller: FSM state type and
// the default word width / depth / address width used by RAM_16 instances.
package ram_fifo_ctrl_pkg;

    localparam int RAM_WIDTH  = 16;
    localparam int RAM_DEPTH  = 8;
    localparam int RAM_ADD_WD = $clog2(RAM_DEPTH);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/RAM_16.sv
// Single-port synchronous RAM: one shared address, write on WrEn, registered
// read data on RdEn.
module RAM_16
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int Width  = RAM_WIDTH,
    parameter int Depth  = RAM_DEPTH,
    parameter int ADD_WD = RAM_ADD_WD
) (
    input  logic              CLK,
    input  logic [Width-1:0]  WrData,
    input  logic [ADD_WD-1:0] Address,
    input  logic              WrEn,
    input  logic              RdEn,
    output logic [Width-1:0]  RdData
);

    logic [Width-1:0] mem [Depth];

    // NOTE: storage arrays are deliberately not reset; only control state needs a known value.
    always_ff @(posedge CLK) begin
        if (WrEn) mem[Address] <= WrData;
        if (RdEn) RdData <= mem[Address];
    end

endmodule

// File: rtl/ram_fifo.sv
// Wrapper pairing ram_fifo_ctrl with its RAM_16 backing store; exposes 'level'
// when RAM_FIFO_CTRL_LEVEL_EN is defined.
module ram_fifo
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int Width  = RAM_WIDTH,
    parameter int Depth  = RAM_DEPTH,
    parameter int ADD_WD = RAM_ADD_WD
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [Width-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [Width-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    ,
    output logic [ADD_WD+1:0] level
`endif
);

    logic [Width-1:0]  wr_data, rd_data;
    logic [ADD_WD-1:0] address;
    logic              wr_en, rd_en;

    ram_fifo_ctrl #(.Width(Width), .Depth(Depth), .ADD_WD(ADD_WD)) u_ctrl (
        .CLK       (CLK),
        .RST       (RST),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .WrData    (wr_data),
        .Address   (address),
        .WrEn      (wr_en),
        .RdEn      (rd_en),
        .RdData    (rd_data)
`ifdef RAM_FIFO_CTRL_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    RAM_16 #(.Width(Width), .Depth(Depth), .ADD_WD(ADD_WD)) u_ram (
        .CLK     (CLK),
        .WrData  (wr_data),
        .Address (address),
        .WrEn    (wr_en),
        .RdEn    (rd_en),
        .RdData  (rd_data)
    );

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of single-port RAM_16; reads take priority over writes.
// Optional RAM_FIFO_CTRL_LEVEL_EN adds a registered 'level' output (total words held).
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int Width  = RAM_WIDTH,
    parameter int Depth  = RAM_DEPTH,
    parameter int ADD_WD = RAM_ADD_WD
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [Width-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [Width-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [Width-1:0]  WrData,
    output logic [ADD_WD-1:0] Address,
    output logic              WrEn,
    output logic              RdEn,
    input  logic [Width-1:0]  RdData
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    ,
    output logic [ADD_WD+1:0] level
`endif
);

    localparam logic [ADD_WD:0]   FULL    = (ADD_WD+1)'(Depth);
    localparam logic [ADD_WD:0]   CNT_ONE = (ADD_WD+1)'(1);
    localparam logic [ADD_WD-1:0] PTR_ONE = ADD_WD'(1);

    state_t            state, state_next;
    logic [ADD_WD-1:0] wr_ptr, rd_ptr;
    logic [ADD_WD:0]   count, count_next;
    logic              out_valid_next;
    logic              rd_issue, wr_issue;

    // RST gates the issue terms so the RAM sees no enables while reset is held.
    always_comb begin
        rd_issue = RST && (state == IDLE) && (count != '0) && (!out_valid || out_ready);
        in_ready = RST && (count != FULL) && !rd_issue;
        wr_issue = in_valid && in_ready;
    end

    assign RdEn    = rd_issue;
    assign WrEn    = wr_issue;
    assign Address = rd_issue ? rd_ptr : wr_ptr;
    assign WrData  = in_data;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rd_issue) state_next = RD_WAIT;
            RD_WAIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count;
        if (rd_issue)      count_next = count - CNT_ONE;
        else if (wr_issue) count_next = count + CNT_ONE;

        out_valid_next = out_valid;
        if (state == RD_WAIT)            out_valid_next = 1'b1;
        else if (out_valid && out_ready) out_valid_next = 1'b0;
    end

    // NOTE: reset is synchronous and active-low, so it is tested inside the clocked block.
    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (wr_issue) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_issue) rd_ptr <= rd_ptr + PTR_ONE;
            count     <= count_next;
            out_valid <= out_valid_next;
            if (state == RD_WAIT) out_data <= RdData;
        end
    end

`ifdef RAM_FIFO_CTRL_LEVEL_EN
    // Words in RAM, plus the output register, plus a read still in flight.
    logic [ADD_WD+1:0] level_next;

    always_comb begin
        level_next = {1'b0, count_next}
                   + {{(ADD_WD+1){1'b0}}, out_valid_next}
                   + {{(ADD_WD+1){1'b0}}, (state_next == RD_WAIT)};
    end

    always_ff @(posedge CLK) begin
        if (!RST) level <= '0;
        else      level <= level_next;
    end
`endif

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

FIFO controller that sits directly upstream of the single-port `RAM_16` memory: it accepts words on a valid/ready push interface and delivers them in order on a valid/ready pop interface. It generates the RAM's `WrData`, `Address`, `WrEn` and `RdEn`, and captures `RdData`. The RAM has one address port, so the controller arbitrates each cycle between one write and one read and never issues both.

## Interface
- `Width`, 16: data word width; matches the RAM.
- `Depth`, 8: RAM entries; power of two.
- `ADD_WD`, 3: address width, log2(`Depth`).

- `CLK` input 1: clock; all state on rising edge.
- `RST` input 1: reset; synchronous and active-low, sampled on the rising edge of `CLK`.
- `in_data` input `Width`: push data.
- `in_valid` input 1: push request.
- `in_ready` output 1: push accepted when `in_valid && in_ready`.
- `out_data` output `Width`: pop data (registered).
- `out_valid` output 1: `out_data` holds a word.
- `out_ready` input 1: consumer takes word when `out_valid && out_ready`.
- `WrData` output `Width`: to RAM; equals `in_data`.
- `Address` output `ADD_WD`: to RAM.
- `WrEn` output 1: to RAM write enable.
- `RdEn` output 1: to RAM read enable.
- `RdData` input `Width`: from RAM; registered by the RAM on the edge where `RdEn` is sampled high.

## Operation
- State: `wr_ptr`, `rd_ptr` (`ADD_WD` bits each, wrap modulo `Depth`); `count` (`ADD_WD+1` bits, words in RAM, 0..`Depth`, excludes output register); FSM {`IDLE`, `RD_WAIT`}; output register (`out_data`, `out_valid`).
- `rd_issue = (state==IDLE) && (count!=0) && (!out_valid || out_ready)`.
- `in_ready = (count!=Depth) && !rd_issue`: read has priority over write.
- `wr_issue = in_valid && in_ready`.
- RAM drive: `RdEn = rd_issue`; `WrEn = wr_issue`; `Address = rd_issue ? rd_ptr : wr_ptr`; `WrEn && RdEn` is never 1.
- On `rd_issue`: `rd_ptr++`, `count--`, go to `RD_WAIT`.
- In `RD_WAIT` (one cycle): load `out_data <= RdData`, `out_valid <= 1`, return to `IDLE`. The port is free in this cycle, so a write is allowed.
- On `wr_issue`: `wr_ptr++`, `count++`.
- A pop handshake without a simultaneous load clears `out_valid`. `out_data` holds its last value.
- `count` changes by at most ±1 per cycle, because read and write are mutually exclusive.
- Full (`count==Depth`): `in_ready=0`; pops still drain. Empty (`count==0`) with `out_valid=0`: no read issued.

## Timing
- Reset (`RST` low at an edge): `wr_ptr=rd_ptr=0`, `count=0`, state `IDLE`, `out_valid=0`, `out_data=0`.
- While `RST` is low, `in_ready`, `WrEn` and `RdEn` are forced to 0.
- Reset mid-read (in `RD_WAIT`) discards the in-flight word.
- Push-to-pop latency into an empty FIFO:
  - Push accepted at edge 0.
  - `RdEn` high in cycle 1.
  - `RD_WAIT` in cycle 2.
  - `out_valid` high from cycle 3.
- Sustained throughput: 1 word per 2 cycles while both sides are active (read, then `RD_WAIT` with write).
- `in_ready`, `WrEn`, `RdEn` and `Address` are combinational from state and `in_valid`/`out_ready`. `out_*` are registered.

## Configuration
- `RAM_FIFO_CTRL_LEVEL_EN` defined: adds output port `level` (`ADD_WD+2` bits) = `count + out_valid + (state==RD_WAIT)`, registered, reset 0. The value is the total words held.
- Macro undefined: port absent; behaviour otherwise identical.

## Structure
- Shared package holds:
  - FSM state typedef (`IDLE`, `RD_WAIT`).
  - Default `Width`/`Depth`/`ADD_WD` constants, shared with `RAM_16` instances.
- No sub-module is required.
- A top wrapper `ram_fifo` instantiates `ram_fifo_ctrl` plus `RAM_16` for bench use.

## Test plan
- Reset, then single push of 35, `out_ready=1`:
  - `WrEn` at address 0.
  - `RdEn` at address 0 one cycle later.
  - `out_valid=1`, `out_data=35` three cycles after the push.
- Push 8 words 1..8 with `out_ready=0`:
  - First word is prefetched into the output register, so `count` reaches 7.
  - A further push of 9 brings `count` to 8; `in_ready=0` with `count==8`.
  - Then drain: pop order 1..9.
- Continuous push and pop of 16 words:
  - `WrEn` and `RdEn` never both high.
  - Pointers wrap 7→0.
  - Data order preserved.
  - Throughput 1 word per 2 cycles.
- Push arriving in the same cycle as `rd_issue` (`count>0`, output empty): `in_ready=0` that cycle, the write lands the next cycle, and no word is lost or duplicated.
- Assert `RST` low during `RD_WAIT` with 3 words stored:
  - Next cycle: `out_valid=0`, `count=0`, pointers 0.
  - A subsequent push/pop of 15 returns 15.
